// File: rtl/imem_loader.sv
// imem_loader: loads a program into instruction memory from a byte stream.
//
// Stream format: a 16-bit little-endian word count N, then N words of four
// bytes each, least-significant byte first. Every assembled word gets a
// one-cycle write on the imem port, at consecutive addresses from BASE_ADDR.
// The CPU core is held in reset until the last word has been written.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LEN_LO  | waiting for word-count low byte
//   LEN_HI  | waiting for word-count high byte; range-check the count
//   DATA    | collecting the four bytes of the current word
//   WRITE   | one-cycle imem write of the assembled word
//   DONE    | load complete, CPU released; waits for reload
//   ERR     | word count too large, CPU held; waits for reload
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous reset, active-low
//   in_valid_i   byte source has in_data_i valid
//   in_data_i    stream byte
//   in_ready_o   loader accepts in_data_i this cycle (registered)
//   reload_i     one-cycle pulse; restarts a load from DONE or ERR
//   mem_we_o     imem write strobe, one cycle per word
//   mem_addr_o   imem word address
//   mem_wdata_o  imem write data
//   cpu_hold_o   1 = keep CPU core in reset
//   done_o       load completed successfully
//   err_o        word count exceeded MAX_WORDS
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              reload_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_W17  = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       rem_q, rem_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       n_full;

  assign xfer   = in_valid_i & in_ready_q;
  assign n_full = {in_data_i, len_lo_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LEN_LO;
      len_lo_q   <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      wbuf_q     <= '0;
      addr_q     <= BASE;
      in_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      wbuf_q     <= wbuf_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // in_ready/done/err/cpu_hold are computed for the state being entered so
  // they change on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    wbuf_d     = wbuf_q;
    addr_d     = addr_q;
    in_ready_d = in_ready_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d = in_data_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          rem_d = n_full;
          if (n_full == 16'd0) begin
            state_d    = S_DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else if ({1'b0, n_full} > MAX_W17) begin
            state_d    = S_ERR;
            in_ready_d = 1'b0;
            err_d      = 1'b1;
          end else begin
            state_d = S_DATA;
            idx_d   = 2'd0;
            addr_d  = BASE;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wbuf_d[{idx_q, 3'b000} +: 8] = in_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - 16'd1;
        if (rem_q > 16'd1) begin
          state_d    = S_DATA;
          in_ready_d = 1'b1;
        end else begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
      end
      S_DONE, S_ERR: begin
        if (reload_i) begin
          state_d    = S_LEN_LO;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          addr_d     = BASE;
        end
      end
      default: begin
        state_d = S_LEN_LO;
      end
    endcase
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wbuf_q;
  assign cpu_hold_o  = cpu_hold_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives byte streams over the
// valid/ready handshake and records every imem write seen on the port.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          we_ready_bad = 0;
  int          we_hold_bad  = 0;

  logic [7:0] prog[14] = '{8'h03, 8'h00, 8'hEF, 8'h00, 8'h80, 8'h00, 8'h13,
                           8'h01, 8'h30, 8'h06, 8'h13, 8'h01, 8'h70, 8'h00};
  logic [7:0]  exp_a[3] = '{8'd0, 8'd1, 8'd2};
  logic [31:0] exp_d[3] = '{32'h008000EF, 32'h06300113, 32'h00700113};

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .reload_i    (reload),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampled mid-cycle, so each WRITE cycle is seen exactly once.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (in_ready) we_ready_bad++;
      if (!cpu_hold) we_hold_bad++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    we_ready_bad = 0;
    we_hold_bad  = 0;
  endtask

  // Presents one byte after 'gap' idle cycles and returns at the negedge
  // following the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_prog(input int max_gap);
    for (int i = 0; i < 14; i++)
      send_byte(prog[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_prog_writes(input string tag);
    checks++;
    if (wr_addr.size() !== 3) begin
      errors++;
      $display("FAIL %s write count: got %0d required 3", tag, wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL %s word%0d: got [%0d]=%08h required [%0d]=%08h",
                   tag, i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s final flags: done=%0b hold=%0b rdy=%0b err=%0b required 1 0 0 0",
               tag, done, cpu_hold, in_ready, err);
    end
    checks++;
    if (we_hold_bad !== 0) begin
      errors++;
      $display("FAIL %s cpu_hold low during write: got %0d required 0", tag, we_hold_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b required 1", in_ready); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %0b required 0", mem_we); end
    checks++;
    if (mem_addr !== 8'd0) begin errors++; $display("FAIL reset mem_addr: got %0d required 0", mem_addr); end
    checks++;
    if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset mem_wdata: got %08h required 0", mem_wdata); end
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: hold=%0b done=%0b err=%0b required 1 0 0", cpu_hold, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program();
    clear_log();
    send_prog(0);
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL program hold in last write: got %0b required 1", cpu_hold);
    end
    repeat (3) @(negedge clk);
    check_prog_writes("program");
    // Bytes offered in DONE must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wr_addr.size() !== 3 || in_ready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done ignores stream: writes=%0d rdy=%0b done=%0b required 3 0 1",
               wr_addr.size(), in_ready, done);
    end
  endtask

  task automatic test_zero_words();
    pulse_reload();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL reload from done: hold=%0b done=%0b err=%0b rdy=%0b addr=%0d required 1 0 0 1 0",
               cpu_hold, done, err, in_ready, mem_addr);
    end
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero words: done=%0b hold=%0b rdy=%0b writes=%0d required 1 0 0 0",
               done, cpu_hold, in_ready, wr_addr.size());
    end
  endtask

  task automatic test_err();
    pulse_reload();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL too many words: err=%0b hold=%0b done=%0b rdy=%0b writes=%0d required 1 1 0 0 0",
               err, cpu_hold, done, in_ready, wr_addr.size());
    end
    pulse_reload();
    checks++;
    if (err !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload from err: err=%0b hold=%0b rdy=%0b required 0 1 1", err, cpu_hold, in_ready);
    end
  endtask

  // N=256 is the largest legal count: must enter DATA, not ERR.
  task automatic test_max_boundary();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL max count accepted: err=%0b rdy=%0b done=%0b required 0 1 0", err, in_ready, done);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random_valid();
    clear_log();
    send_prog(3);
    repeat (3) @(negedge clk);
    check_prog_writes("random_valid");
    checks++;
    if (we_ready_bad !== 0) begin
      errors++;
      $display("FAIL in_ready high during write: got %0d required 0", we_ready_bad);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_reload();
    clear_log();
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL mid reset values: rdy=%0b hold=%0b addr=%0d wdata=%08h required 1 1 0 0",
               in_ready, cpu_hold, mem_addr, mem_wdata);
    end
    checks++;
    if (wr_addr.size() !== 1 || wr_data[0] !== exp_d[0] || wr_addr[0] !== exp_a[0]) begin
      errors++;
      $display("FAIL mid reset partial writes: count=%0d word0=%08h required 1 %08h",
               wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx, exp_d[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    send_prog(0);
    repeat (3) @(negedge clk);
    check_prog_writes("reset_resend");
  endtask

  task automatic test_reload_single();
    pulse_reload();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL reload single word: count=%0d data=%08h required 1 12345678",
               wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx);
    end
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reload single flags: done=%0b hold=%0b required 1 0", done, cpu_hold);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_program();
    test_zero_words();
    test_err();
    test_max_boundary();
    test_random_valid();
    test_reset_mid_load();
    test_reload_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
